// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: FSM state encoding and default sizes shared by the SPI slave files.
package spi_slave_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        END    = 2'd2
    } state_t;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FIFO_DEPTH = 4;
endpackage

// File: rtl/spi_slave_fifo.sv
// spi_slave_fifo: valid/ready receive FIFO with wrap-bit pointers; a push into a full FIFO is accepted when a pop happens in the same cycle.
module spi_slave_fifo
    import spi_slave_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_valid,
    output logic              push_ready,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    input  logic              pop_ready
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic empty, full, do_push, do_pop;
    assign empty      = wr_ptr == rd_ptr;
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_valid  = !empty;
    assign do_pop     = pop_valid && pop_ready;
    assign push_ready = !full || do_pop;
    assign do_push    = push_valid && push_ready;
    // Head reads as zero while empty, so the storage itself needs no reset.
    assign pop_data   = empty ? '0 : mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + (AW+1)'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + (AW+1)'(1) : rd_ptr;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI mode-0 slave with oversampled inputs, rx buffering and a tx return word.
// Define SPI_SLAVE_FIFO_EN for a FIFO_DEPTH-entry rx FIFO; otherwise a single holding register.
module spi_slave_rx
    import spi_slave_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              nss,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              overrun,
    input  logic              overrun_clr
);
    localparam int CW = $clog2(DATA_W) + 1;
    state_t state_q, state_d;
    logic [1:0] sclk_s, nss_s, mosi_s;
    logic sclk_d, nss_d;
    logic sclk_rise, sclk_fall, nss_fall, nss_rise;
    logic [CW-1:0] bit_cnt;
    logic [DATA_W-1:0] rx_shift, tx_shift, tx_hold;
    logic tx_full, load_tx, shift_rx, shift_tx, push_valid, push_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s <= 2'b00;
            nss_s  <= 2'b11;
            mosi_s <= 2'b00;
            sclk_d <= 1'b0;
            nss_d  <= 1'b1;
        end else begin
            sclk_s <= {sclk_s[0], sclk};
            nss_s  <= {nss_s[0], nss};
            mosi_s <= {mosi_s[0], mosi};
            sclk_d <= sclk_s[1];
            nss_d  <= nss_s[1];
        end
    end
    assign sclk_rise = sclk_s[1] && !sclk_d;
    assign sclk_fall = !sclk_s[1] && sclk_d;
    assign nss_fall  = !nss_s[1] && nss_d;
    assign nss_rise  = nss_s[1] && !nss_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) state_d = nss_fall ? ACTIVE : IDLE;
        else if (nss_rise) state_d = IDLE;
        else if (state_q == END) state_d = ACTIVE;
        else if (sclk_rise && bit_cnt == CW'(DATA_W - 1)) state_d = END;
    end
    // The fall that follows a word's last rise arrives with bit_cnt already cleared, so it must not shift out the freshly loaded MSB.
    always_comb begin
        load_tx    = state_d == ACTIVE && state_q != ACTIVE;
        shift_rx   = state_q == ACTIVE && sclk_rise;
        shift_tx   = state_q == ACTIVE && sclk_fall && bit_cnt != '0;
        push_valid = state_q == END;
        miso       = state_q == IDLE ? 1'b1 : tx_shift[DATA_W-1];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '1;
            tx_hold  <= '0;
            tx_full  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            bit_cnt  <= state_q != ACTIVE ? '0 : shift_rx ? bit_cnt + CW'(1) : bit_cnt;
            rx_shift <= shift_rx ? {rx_shift[DATA_W-2:0], mosi_s[1]} : rx_shift;
            tx_shift <= load_tx ? (tx_full ? tx_hold : '1) : shift_tx ? {tx_shift[DATA_W-2:0], 1'b1} : tx_shift;
            tx_hold  <= tx_valid && !tx_full ? tx_data : tx_hold;
            tx_full  <= (tx_full && !load_tx) || (tx_valid && !tx_full);
            overrun  <= push_valid && !push_ready ? 1'b1 : overrun_clr ? 1'b0 : overrun;
        end
    end
    assign tx_ready = !tx_full;
`ifdef SPI_SLAVE_FIFO_EN
    spi_slave_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_data  (rx_shift),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .pop_data   (rx_data),
        .pop_valid  (rx_valid),
        .pop_ready  (rx_ready)
    );
`else
    logic unused_depth;
    assign unused_depth = FIFO_DEPTH[0];
    assign push_ready   = !rx_valid || rx_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else if (push_valid && push_ready) begin
            rx_valid <= 1'b1;
            rx_data  <= rx_shift;
        end else if (rx_ready) begin
            rx_valid <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: self-checking bench for spi_slave_rx with a queue-based rx/tx reference model.
module tb_spi_slave_rx;
    logic clk_tb = 1'b0;
    logic reset_tb = 1'b0;
    logic sclk, nss, mosi, miso;
    logic [7:0] rx_data, tx_data;
    logic rx_valid, rx_ready, tx_valid, tx_ready, overrun, overrun_clr;

`ifdef SPI_SLAVE_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    spi_slave_rx #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
        .clk         (clk_tb),
        .rst_n       (reset_tb),
        .sclk        (sclk),
        .nss         (nss),
        .mosi        (mosi),
        .miso        (miso),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk_tb = ~clk_tb;

    typedef struct packed {
        logic [7:0] mo;
        logic [7:0] tx;
        logic       tx_en;
    } vec_t;

    vec_t vecs [5];
    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q [$];
    logic ov_m = 1'b0;
    logic tx_pend = 1'b0;
    logic [7:0] tx_val = 8'h00;

    task automatic tick(input int n);
        repeat (n) @(negedge clk_tb);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic offer_tx(input logic [7:0] v);
        chk("tx_ready_before_load", {31'd0, tx_ready}, 32'd1);
        tx_data  = v;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tx_pend  = 1'b1;
        tx_val   = v;
    endtask

    // The slave returns the held word if one was offered before the word started, else all ones.
    task automatic word_start(output logic [7:0] e);
        e = tx_pend ? tx_val : 8'hFF;
        tx_pend = 1'b0;
    endtask

    task automatic rx_model(input logic [7:0] w);
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
        else ov_m = 1'b1;
    endtask

    task automatic xfer(input logic [7:0] mo, input int nb, input logic ld, input logic [7:0] nx,
                        output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nb; i--) begin
            mosi = mo[i];
            if (ld && i == 4) begin
                offer_tx(nx);
                tick(3);
            end else begin
                tick(4);
            end
            mi[i] = miso;
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_begin();
        nss = 1'b0;
        tick(8);
    endtask

    task automatic frame_end();
        tick(4);
        nss  = 1'b1;
        mosi = 1'b0;
        tick(8);
    endtask

    task automatic send_frame(input logic [7:0] mo);
        logic [7:0] e, mi;
        frame_begin();
        word_start(e);
        xfer(mo, 8, 1'b0, 8'h00, mi);
        chk("miso_word", {24'd0, mi}, {24'd0, e});
        rx_model(mo);
        frame_end();
    endtask

    task automatic drain();
        logic [7:0] w;
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk("rx_valid", {31'd0, rx_valid}, 32'd1);
            chk("rx_data", {24'd0, rx_data}, {24'd0, w});
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
        end
        chk("rx_empty", {31'd0, rx_valid}, 32'd0);
    endtask

    task automatic clear_overrun();
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        ov_m = 1'b0;
        chk("overrun_clr", {31'd0, overrun}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e, mi;
        vecs[0] = '{8'h3C, 8'hA5, 1'b1};
        vecs[1] = '{8'h00, 8'h00, 1'b0};
        vecs[2] = '{8'hFF, 8'h5A, 1'b1};
        vecs[3] = '{8'h81, 8'hFF, 1'b0};
        vecs[4] = '{8'h7E, 8'h01, 1'b1};
        sclk = 1'b0; nss = 1'b1; mosi = 1'b0;
        rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; overrun_clr = 1'b0;
        tick(3);
        chk("reset_miso", {31'd0, miso}, 32'd1);
        chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
        chk("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("reset_overrun", {31'd0, overrun}, 32'd0);
        reset_tb = 1'b1;
        tick(2);

        foreach (vecs[k]) begin
            if (vecs[k].tx_en) offer_tx(vecs[k].tx);
            send_frame(vecs[k].mo);
            chk("overrun_vec", {31'd0, overrun}, {31'd0, ov_m});
            drain();
        end

        for (int w = 1; w <= 5; w++) send_frame(8'(w));
        chk("overrun_set", {31'd0, overrun}, 32'd1);
        drain();
        clear_overrun();

        frame_begin();
        word_start(e);
        xfer(8'hF0, 5, 1'b0, 8'h00, mi);
        frame_end();
        chk("partial_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("partial_overrun", {31'd0, overrun}, 32'd0);
        send_frame(8'h96);
        drain();

        offer_tx(8'h81);
        frame_begin();
        word_start(e);
        xfer(8'h11, 8, 1'b1, 8'h42, mi);
        chk("b2b_miso0", {24'd0, mi}, {24'd0, e});
        rx_model(8'h11);
        word_start(e);
        xfer(8'h22, 8, 1'b0, 8'h00, mi);
        chk("b2b_miso1", {24'd0, mi}, {24'd0, e});
        rx_model(8'h22);
        frame_end();
        if (DEPTH == 1) clear_overrun();
        drain();

        repeat (16) begin
            if ($urandom_range(0, 1) == 1) offer_tx(8'($urandom));
            send_frame(8'($urandom));
            chk("overrun_rand", {31'd0, overrun}, {31'd0, ov_m});
            if ($urandom_range(0, 2) == 0) drain();
        end
        drain();
        clear_overrun();

        send_frame(8'h5A);
        send_frame(8'hA7);
        frame_begin();
        word_start(e);
        xfer(8'hFF, 3, 1'b0, 8'h00, mi);
        reset_tb = 1'b0;
        nss = 1'b1;
        sclk = 1'b0;
        tick(2);
        chk("midreset_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("midreset_miso", {31'd0, miso}, 32'd1);
        chk("midreset_overrun", {31'd0, overrun}, 32'd0);
        chk("midreset_tx_ready", {31'd0, tx_ready}, 32'd1);
        exp_q.delete();
        ov_m = 1'b0;
        tx_pend = 1'b0;
        reset_tb = 1'b1;
        tick(4);
        send_frame(8'hC3);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
